// File: rtl/dma_reg_pkg.sv
// Shared definitions for the DMA priority block: FSM encoding, command-register
// bit positions, priority-mode constants and a one-hot encoder helper.
package dma_reg_pkg;

  localparam int NUM_CH = 4;

  // State indices shared with the timing control; states are one-hot on these bits.
  localparam int ST_IDLE_IDX    = 0;
  localparam int ST_ARB_IDX     = 1;
  localparam int ST_HOLD_IDX    = 2;
  localparam int ST_SERVICE_IDX = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'(1 << ST_IDLE_IDX),
    ST_ARB     = 4'(1 << ST_ARB_IDX),
    ST_HOLD    = 4'(1 << ST_HOLD_IDX),
    ST_SERVICE = 4'(1 << ST_SERVICE_IDX)
  } dma_state_e;

  localparam int CMD_DISABLE_BIT    = 2;
  localparam int CMD_ROTATE_BIT     = 4;
  localparam int CMD_DREQ_SENSE_BIT = 6;
  localparam int CMD_DACK_SENSE_BIT = 7;

  localparam logic PRIO_FIXED  = 1'b0;
  localparam logic PRIO_ROTATE = 1'b1;

  function automatic logic [1:0] onehot_to_ch(input logic [NUM_CH-1:0] oh);
    logic [1:0] ch;
    ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) ch = 2'(i);
    end
    return ch;
  endfunction

endpackage

// File: rtl/dma_prio_resolve.sv
// Combinational priority resolver: scans requests starting at the base channel
// (ptr when rotating, 0 when fixed) and returns the first one as a one-hot winner.
module dma_prio_resolve
  import dma_reg_pkg::*;
(
  input  logic [NUM_CH-1:0] eff_i,
  input  logic [1:0]        ptr_i,
  input  logic              rotate_i,
  output logic [NUM_CH-1:0] winner_o
);

  logic [1:0] base;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    base     = (rotate_i == PRIO_FIXED) ? 2'd0 : ptr_i;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + 2'(k);
      if (!found && eff_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority.sv
// DMA request prioritiser: samples channel requests, arbitrates one winner,
// runs the hold-request handshake with the CPU and drives DACK during service.
module dma_priority
  import dma_reg_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] requestReg,
  input  logic [7:0]        cmdReg,
  input  logic              HLDA,
  input  logic              timeout,
  output logic [NUM_CH-1:0] VALID_DREQ,
  output logic              hrq,
  output logic [NUM_CH-1:0] DACK,
  output logic [1:0]        activeCh,
  output logic              busy
);

  dma_state_e        state_q, state_d;
  logic [NUM_CH-1:0] eff_q, eff_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [NUM_CH-1:0] winner;
  logic              rotate;
  logic              in_service;
  logic              unused_cmd;

  assign rotate     = (cmdReg[CMD_ROTATE_BIT] == PRIO_ROTATE);
  assign in_service = (state_q == ST_SERVICE);
  assign unused_cmd = ^{cmdReg[1:0], cmdReg[3], cmdReg[5]};

  // Software request bypasses both pin polarity and the mask.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign eff_d[gi] = ((DREQ[gi] ^ cmdReg[CMD_DREQ_SENSE_BIT]) & ~maskReg[gi])
                         | requestReg[gi];
      assign DACK[gi]  = (in_service & grant_q[gi]) ^ ~cmdReg[CMD_DACK_SENSE_BIT];
    end
  endgenerate

  dma_prio_resolve u_resolve (
    .eff_i    (eff_q),
    .ptr_i    (ptr_q),
    .rotate_i (rotate),
    .winner_o (winner)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      eff_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      eff_q   <= eff_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if ((|eff_q) && !cmdReg[CMD_DISABLE_BIT]) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (eff_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          grant_d = winner;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (HLDA) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        // Losing the bus wins over a coincident timeout: an aborted transfer
        // must not rotate priority away from the interrupted channel.
        if (!HLDA) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (timeout) begin
          state_d = ST_IDLE;
          grant_d = '0;
          if (rotate) ptr_d = onehot_to_ch(grant_q) + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign hrq        = (state_q == ST_HOLD) || in_service;
  assign busy       = (state_q != ST_IDLE);
  assign VALID_DREQ = in_service ? grant_q : '0;
  assign activeCh   = onehot_to_ch(grant_q);

endmodule

// File: tb/tb_dma_priority.sv
// Scoreboard bench for dma_priority: expected grants are queued by the stimulus
// and popped by a monitor at the start of each service window.
module tb_dma_priority;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ, maskReg, requestReg;
  logic [7:0] cmdReg;
  logic       HLDA, timeout;
  logic [3:0] VALID_DREQ, DACK;
  logic       hrq, busy;
  logic [1:0] activeCh;

  logic       hlda_en;
  int         n_tests = 0;
  int         n_fail  = 0;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] ch;
    logic [3:0] dack;
  } exp_t;

  exp_t exp_q[$];

  dma_priority dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DREQ       (DREQ),
    .maskReg    (maskReg),
    .requestReg (requestReg),
    .cmdReg     (cmdReg),
    .HLDA       (HLDA),
    .timeout    (timeout),
    .VALID_DREQ (VALID_DREQ),
    .hrq        (hrq),
    .DACK       (DACK),
    .activeCh   (activeCh),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end else begin
      $display("[TB] ok %s = %h (t=%0t)", name, act, $time);
    end
  endtask

  function automatic exp_t mk(input int ch, input logic [7:0] cmd);
    exp_t e;
    e.grant = 4'b0001 << ch;
    e.ch    = 2'(ch);
    e.dack  = cmd[7] ? e.grant : ~e.grant;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // CPU model: HLDA follows hrq one cycle later unless the test withdraws it.
  initial begin
    HLDA = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      HLDA = hrq && hlda_en;
    end
  end

  // Monitor: pops one expectation at the first cycle of every service window.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if ((VALID_DREQ != 4'b0) && !prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_grant: got VALID_DREQ=%b, required none", VALID_DREQ);
        end else begin
          e = exp_q.pop_front();
          check("grant_valid_dreq", {4'b0, VALID_DREQ}, {4'b0, e.grant});
          check("grant_activeCh",   {6'b0, activeCh},   {6'b0, e.ch});
          check("grant_dack",       {4'b0, DACK},       {4'b0, e.dack});
        end
      end
      prev = (VALID_DREQ != 4'b0);
    end
  end

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (VALID_DREQ != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_grant: got no grant within 40 cycles, required a grant");
    end
  endtask

  // Wait for service, retarget requests, then end the transfer with a timeout pulse.
  task automatic serve(input logic [3:0] next_dreq, input logic [3:0] next_req);
    bit ok;
    wait_grant(ok);
    if (ok) begin
      DREQ       = next_dreq;
      requestReg = next_req;
      tick(2);
      timeout = 1'b1;
      tick(1);
      timeout = 1'b0;
      check("post_timeout_valid", {4'b0, VALID_DREQ}, 8'h00);
      check("post_timeout_hrq",   {7'b0, hrq},        8'h00);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET      = 1'b1;
    DREQ       = 4'b0;
    maskReg    = 4'b0;
    requestReg = 4'b0;
    cmdReg     = 8'h00;
    timeout    = 1'b0;
    hlda_en    = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(1);
  endtask

  initial begin
    bit ok;
    RESET = 1'b1; DREQ = 4'b0; maskReg = 4'b0; requestReg = 4'b0;
    cmdReg = 8'h00; timeout = 1'b0; hlda_en = 1'b1;
    tick(2);
    check("reset_hrq",        {7'b0, hrq},        8'h00);
    check("reset_valid_dreq", {4'b0, VALID_DREQ}, 8'h00);
    check("reset_dack",       {4'b0, DACK},       8'h0F);
    check("reset_activeCh",   {6'b0, activeCh},   8'h00);
    check("reset_busy",       {7'b0, busy},       8'h00);
    RESET = 1'b0;
    tick(1);

    // Fixed priority: ch1 beats ch3, then ch3 after ch1 is withdrawn.
    exp_q.push_back(mk(1, 8'h00));
    exp_q.push_back(mk(3, 8'h00));
    DREQ = 4'b1010;
    serve(4'b1000, 4'b0);
    serve(4'b0000, 4'b0);

    // Rotating priority with all channels requesting.
    do_reset();
    cmdReg = 8'h10;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(i % 4, 8'h10));
    DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) serve((i == 4) ? 4'b0000 : 4'b1111, 4'b0);

    // Inverted DREQ and DACK sense.
    do_reset();
    cmdReg = 8'hC0;
    DREQ   = 4'b1110;
    tick(1);
    check("pol_dack_idle", {4'b0, DACK}, 8'h00);
    exp_q.push_back(mk(0, 8'hC0));
    serve(4'b1111, 4'b0);
    check("pol_dack_after", {4'b0, DACK}, 8'h00);
    cmdReg = 8'h00;
    DREQ   = 4'b0;

    // Masked pin is ignored; software request overrides the mask.
    do_reset();
    maskReg = 4'b0001;
    DREQ    = 4'b0001;
    tick(6);
    check("mask_no_hrq",  {7'b0, hrq},  8'h00);
    check("mask_no_busy", {7'b0, busy}, 8'h00);
    exp_q.push_back(mk(0, 8'h00));
    requestReg = 4'b0001;
    serve(4'b0000, 4'b0000);

    // HLDA abort on ch2 keeps ptr, so ch2 is re-granted first.
    do_reset();
    cmdReg = 8'h10;
    exp_q.push_back(mk(1, 8'h10));
    exp_q.push_back(mk(2, 8'h10));
    exp_q.push_back(mk(2, 8'h10));
    DREQ = 4'b0010;
    serve(4'b1111, 4'b0);
    wait_grant(ok);
    if (ok) begin
      hlda_en = 1'b0;
      tick(1);
      check("abort_busy", {7'b0, busy}, 8'h00);
      check("abort_hrq",  {7'b0, hrq},  8'h00);
      hlda_en = 1'b1;
      serve(4'b0000, 4'b0);
    end

    // Asynchronous reset in service drops hrq and DACK without a clock edge.
    do_reset();
    exp_q.push_back(mk(0, 8'h00));
    DREQ = 4'b0001;
    wait_grant(ok);
    DREQ = 4'b0000;
    #1;
    RESET = 1'b1;
    #1;
    check("async_rst_hrq",   {7'b0, hrq},        8'h00);
    check("async_rst_dack",  {4'b0, DACK},       8'h0F);
    check("async_rst_valid", {4'b0, VALID_DREQ}, 8'h00);
    check("async_rst_busy",  {7'b0, busy},       8'h00);
    tick(2);
    RESET = 1'b0;
    tick(4);
    check("post_rst_idle", {7'b0, busy}, 8'h00);

    tick(3);
    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
